// File: rtl/btc_miner_host.sv
// btc_miner_host: host side of the tt_um_bitcoin rq/rdy byte link.
// Serves the padded message with a live nonce, collects the sha256d result,
// and relaunches with nonce+1 until hash < target or the budget is spent.
module btc_miner_host #(
    parameter int unsigned NONCE_BASE = 76,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   chip_uo,
    input  logic         chip_rq,
    input  logic         chip_done,
    output logic [7:0]   chip_ui,
    output logic         chip_start,
    output logic         chip_rdy,
    input  logic         cfg_we,
    input  logic [6:0]   cfg_addr,
    input  logic [7:0]   cfg_wdata,
    input  logic         go,
    input  logic [31:0]  nonce_init,
    input  logic [31:0]  max_iter,
    input  logic [255:0] target,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout_err,
    output logic [255:0] hash,
    output logic [31:0]  nonce
);
    typedef enum logic [2:0] {IDLE, START, FEED, READ, CHECK} state_t;

    localparam logic [6:0] NB = 7'(NONCE_BASE);

    state_t         state_q;
    logic [7:0]     mem_q [128];
    logic [31:0]    cur_q, iter_q, wd_q, nonce_q;
    logic [6:0]     k_q;
    logic           rq_q, done_q;
    logic [7:0]     chip_ui_q;
    logic           chip_start_q, chip_rdy_q, busy_q, found_q, exhausted_q, timeout_q;
    logic [255:0]   hash_q;

    logic [6:0]     a_off;
    logic [7:0]     feed_byte;
    logic [31:0]    lim, iter_d;
    logic           edge_seen, wd_hit;

    assign chip_ui     = chip_ui_q;
    assign chip_start  = chip_start_q;
    assign chip_rdy    = chip_rdy_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign timeout_err = timeout_q;
    assign hash        = hash_q;
    assign nonce       = nonce_q;

    // Byte selection for the chip, loop limit and watchdog expiry.
    always_comb begin
        a_off     = chip_uo[6:0] - NB;
        feed_byte = (a_off < 7'd4) ? cur_q[{a_off[1:0], 3'b000} +: 8] : mem_q[chip_uo[6:0]];
        lim       = (max_iter == 32'd0) ? 32'd1 : max_iter;
        iter_d    = iter_q + 32'd1;
        edge_seen = (chip_rq != rq_q) || (chip_done != done_q);
        wd_hit    = !edge_seen && (wd_q >= TIMEOUT - 32'd1);
    end

    // Message buffer: host writes only while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && cfg_we) mem_q[cfg_addr] <= cfg_wdata;
    end

    // Mining FSM with handshake, hash capture, watchdog and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            iter_q       <= '0;
            wd_q         <= '0;
            k_q          <= '0;
            rq_q         <= 1'b0;
            done_q       <= 1'b0;
            chip_ui_q    <= '0;
            chip_start_q <= 1'b0;
            chip_rdy_q   <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            timeout_q    <= 1'b0;
            hash_q       <= '0;
            nonce_q      <= '0;
        end else begin
            rq_q         <= chip_rq;
            done_q       <= chip_done;
            chip_start_q <= 1'b0;
            wd_q         <= (edge_seen || !(state_q == FEED || state_q == READ)) ? 32'd0 : wd_q + 32'd1;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        cur_q        <= nonce_init;
                        iter_q       <= '0;
                        found_q      <= 1'b0;
                        exhausted_q  <= 1'b0;
                        timeout_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        chip_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: state_q <= FEED;
                FEED: begin
                    if (wd_hit) begin
                        timeout_q  <= 1'b1;
                        chip_rdy_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (chip_done) begin
                        k_q        <= '0;
                        chip_rdy_q <= chip_rdy_q & chip_rq;
                        state_q    <= READ;
                    end else if (chip_rq && !chip_rdy_q) begin
                        chip_ui_q  <= feed_byte;
                        chip_rdy_q <= 1'b1;
                    end else if (!chip_rq) begin
                        chip_rdy_q <= 1'b0;
                    end
                end
                READ: begin
                    if (wd_hit) begin
                        timeout_q  <= 1'b1;
                        chip_rdy_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (done_q && !chip_done) begin
                        chip_rdy_q <= 1'b0;
                        if (k_q == 7'd32) begin
                            state_q <= CHECK;
                        end else begin
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end else if (chip_rq && !chip_rdy_q) begin
                        if (k_q < 7'd32) hash_q[{5'd31 - k_q[4:0], 3'b000} +: 8] <= chip_uo;
                        if (k_q != 7'd127) k_q <= k_q + 7'd1;
                        chip_rdy_q <= 1'b1;
                    end else if (!chip_rq) begin
                        chip_rdy_q <= 1'b0;
                    end
                end
                CHECK: begin
                    nonce_q <= cur_q;
                    iter_q  <= iter_d;
                    if (hash_q < target) begin
                        found_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (iter_d >= lim) begin
                        exhausted_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        cur_q        <= cur_q + 32'd1;
                        chip_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
